input_conditioner: RTL

- Conditions the raw board inputs (active-low push-buttons, slide switches) before they reach the Nios platform's pio_btn / pio_sw PIO ports.
- Provides per-input 2-flop synchronisation, counter-based debounce, and polarity normalisation to active-high.
- Generates single-cycle press/release pulses for the buttons.
- Sits directly upstream of the platform instance in the board top level, in the clk_50 domain.

---
 rtl/input_cond_pkg.sv | 17 +
 rtl/input_conditioner_if.sv | 24 ++
 rtl/input_conditioner_debounce_cell.sv | 60 ++++++
 rtl/input_conditioner.sv | 88 ++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
// Shared types and helpers for the board input conditioner.
package input_cond_pkg;

  localparam int DB_CYCLES_50MHZ_10MS = 500000;

  // Counter width for a debounce window of n cycles (at least one bit).
  function automatic int db_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } db_out_t;

endpackage

// File: rtl/input_conditioner_if.sv
// Raw pad inputs and conditioned outputs of input_conditioner, grouped as one bus.
interface input_conditioner_if #(
  parameter int NUM_BTN = 4,
  parameter int NUM_SW  = 9
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_SW-1:0]  sw_raw;
  logic [NUM_BTN-1:0] btn_latch_clr;
  logic [NUM_BTN-1:0] btn_clean;
  logic [NUM_SW-1:0]  sw_clean;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_latched;

  modport master (
    output btn_raw, sw_raw, btn_latch_clr,
    input  btn_clean, sw_clean, btn_press, btn_release, btn_latched
  );

  modport slave (
    input  btn_raw, sw_raw, btn_latch_clr,
    output btn_clean, sw_clean, btn_press, btn_release, btn_latched
  );
endinterface

// File: rtl/input_conditioner_debounce_cell.sv
// One input bit: 2-flop synchroniser, optional inversion, counter debounce and
// registered rise/fall pulses that coincide with the accepted level change.
module debounce_cell
  import input_cond_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_50MHZ_10MS,
  parameter bit RESET_LEVEL = 1'b0,
  parameter bit INVERT      = 1'b0
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    raw,
  output db_out_t q
);
  localparam int             CW   = db_width(DB_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DB_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic          rise_reg;
  logic          fall_reg;
  logic [CW-1:0] count_reg;
  logic          level;

  assign level = sync2_reg ^ INVERT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg  <= RESET_LEVEL;
      sync2_reg  <= RESET_LEVEL;
      stable_reg <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
      count_reg  <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      if (level == stable_reg) begin
        count_reg <= '0;
      end else if (count_reg == LAST) begin
        // Pulse is raised on the same edge that accepts the level, so it is
        // high during the one cycle following the change of stable.
        stable_reg <= level;
        count_reg  <= '0;
        rise_reg   <= level;
        fall_reg   <= ~level;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign q.level = stable_reg;
  assign q.rise  = rise_reg;
  assign q.fall  = fall_reg;

endmodule

// File: rtl/input_conditioner.sv
// Debounces board buttons/switches into clean active-high levels plus button
// press/release pulses. Define INPUT_COND_STICKY_EN for sticky press flags.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int NUM_BTN        = 4,
  parameter int NUM_SW         = 9,
  parameter int DB_CYCLES      = DB_CYCLES_50MHZ_10MS,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input logic                clk_50,
  input logic                reset,
  input_conditioner_if.slave bus
);
  localparam bit BTN_INV = (BTN_ACTIVE_LOW != 0);

  db_out_t            btn_db [NUM_BTN];
  db_out_t            sw_db  [NUM_SW];
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_fall;
  logic [NUM_SW-1:0]  sw_level;
  logic [NUM_SW-1:0]  sw_rise_unused;
  logic [NUM_SW-1:0]  sw_fall_unused;
  logic               unused_inputs;

  genvar gi;

  // Buttons idle at the inactive pad level, so the synchroniser resets there.
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      debounce_cell #(
        .DB_CYCLES  (DB_CYCLES),
        .RESET_LEVEL(BTN_INV),
        .INVERT     (BTN_INV)
      ) u_cell (
        .clk(clk_50),
        .rst(reset),
        .raw(bus.btn_raw[gi]),
        .q  (btn_db[gi])
      );
      assign btn_level[gi] = btn_db[gi].level;
      assign btn_rise[gi]  = btn_db[gi].rise;
      assign btn_fall[gi]  = btn_db[gi].fall;
    end

    for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
      debounce_cell #(
        .DB_CYCLES  (DB_CYCLES),
        .RESET_LEVEL(1'b0),
        .INVERT     (1'b0)
      ) u_cell (
        .clk(clk_50),
        .rst(reset),
        .raw(bus.sw_raw[gi]),
        .q  (sw_db[gi])
      );
      assign sw_level[gi]       = sw_db[gi].level;
      assign sw_rise_unused[gi] = sw_db[gi].rise;
      assign sw_fall_unused[gi] = sw_db[gi].fall;
    end
  endgenerate

  assign bus.btn_clean   = btn_level;
  assign bus.sw_clean    = sw_level;
  assign bus.btn_press   = btn_rise;
  assign bus.btn_release = btn_fall;

`ifdef INPUT_COND_STICKY_EN
  logic [NUM_BTN-1:0] latched_reg;

  // A press arriving together with a clear keeps the flag set.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      latched_reg <= '0;
    end else begin
      latched_reg <= (latched_reg & ~bus.btn_latch_clr) | btn_rise;
    end
  end

  assign bus.btn_latched = latched_reg;
  assign unused_inputs   = ^{sw_rise_unused, sw_fall_unused};
`else
  assign bus.btn_latched = '0;
  assign unused_inputs   = ^{sw_rise_unused, sw_fall_unused, bus.btn_latch_clr};
`endif

endmodule
